// File: rtl/writeback_unit.sv
// Writeback arbiter: integer results > buffered loads > direct load, one RF write per cycle.
// Optional stall counter output o_stall_cnt enabled by defining WB_STALL_COUNT_EN.
module writeback_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned MEM_FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_int_valid,
  input  logic [XLEN-1:0] i_int_res,
  input  logic [4:0]      i_int_waddr,
  input  logic            i_mem_valid,
  output logic            o_mem_ready,
  input  logic [XLEN-1:0] i_mem_res,
  input  logic [4:0]      i_mem_waddr,
  output logic            o_rf_we,
  output logic [4:0]      o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata,
  output logic            o_idle
`ifdef WB_STALL_COUNT_EN
  ,
  output logic [31:0]     o_stall_cnt
`endif
);

  localparam int unsigned PW = $clog2(MEM_FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(MEM_FIFO_DEPTH);

  logic [XLEN-1:0] fifo_data_q [MEM_FIFO_DEPTH];
  logic [4:0]      fifo_addr_q [MEM_FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ready_q, ready_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic fifo_empty, accept, sel_head, sel_direct, push, pop;

  always_comb begin
    fifo_empty = (count_q == '0);
    accept     = i_mem_valid && ready_q;
    sel_head   = !i_int_valid && !fifo_empty;
    // A direct write is only allowed when nothing is buffered, so loads never reorder.
    sel_direct = !i_int_valid && fifo_empty && accept;
    push       = accept && !sel_direct;
    pop        = sel_head;

    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    ready_d = (count_d != FULL);

    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (i_int_valid) begin
      waddr_d = i_int_waddr;
      wdata_d = i_int_res;
      we_d    = (i_int_waddr != 5'd0);
    end else if (sel_head) begin
      waddr_d = fifo_addr_q[rd_ptr_q];
      wdata_d = fifo_data_q[rd_ptr_q];
      we_d    = (fifo_addr_q[rd_ptr_q] != 5'd0);
    end else if (sel_direct) begin
      waddr_d = i_mem_waddr;
      wdata_d = i_mem_res;
      we_d    = (i_mem_waddr != 5'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= i_mem_res;
      fifo_addr_q[wr_ptr_q] <= i_mem_waddr;
    end
  end

  assign o_mem_ready = ready_q;
  assign o_rf_we     = we_q;
  assign o_rf_waddr  = waddr_q;
  assign o_rf_wdata  = wdata_q;
  assign o_idle      = fifo_empty && !we_q;

`ifdef WB_STALL_COUNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (!fifo_empty && i_int_valid && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule
